// File: rtl/addsub_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial add/sub scheduler.
package addsub_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple full-adder chain; the only adder in the scheduler.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                cout_o
);
    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[NIBBLE_W];
endmodule

// File: rtl/addsub_sched.sv
// Round-robin arbiter and nibble-serial sequencer around one shared 4-bit adder.
//   state  | meaning
//   S_IDLE | grant a requester, latch operands on transfer
//   S_RUN  | one nibble per cycle through the shared adder, LSB first
//   S_DONE | hold response until consumer accepts
module addsub_sched
    import addsub_pkg::*;
#(
    parameter int NIBBLES    = 2,
    parameter int FIRST_PRIO = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      req_valid_i,
    output logic [1:0]                      req_ready_o,
    input  logic [1:0][NIBBLE_W*NIBBLES-1:0] req_a_i,
    input  logic [1:0][NIBBLE_W*NIBBLES-1:0] req_b_i,
    input  logic [1:0]                      req_sub_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_id_o,
    output logic [NIBBLE_W*NIBBLES-1:0]     rsp_sum_o,
    output logic                            rsp_cout_o,
    output logic                            rsp_ovf_o
);
    localparam int W = NIBBLE_W * NIBBLES;

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          id_q, id_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    nib_cnt_q, nib_cnt_d;

    logic                gnt;
    logic                xfer;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_c;

    // Reset also masks the combinational ready so nothing is accepted while held.
    always_comb begin
        gnt         = req_valid_i[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        req_ready_o = '0;
        if (state_q == S_IDLE && (|req_valid_i) && !rst_i) begin
            req_ready_o[gnt] = 1'b1;
        end
        xfer = |(req_valid_i & req_ready_o);
    end

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (nib_cnt_q == 4'(n)) begin
                nib_a = a_q[n*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_addsub u_adder (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .s_o    (nib_s),
        .cout_o (nib_c)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        id_d      = id_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        nib_cnt_d = nib_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    a_d       = req_a_i[gnt];
                    b_d       = req_b_i[gnt] ^ {W{req_sub_i[gnt]}};
                    carry_d   = req_sub_i[gnt];
                    id_d      = gnt;
                    nib_cnt_d = '0;
                    rr_ptr_d  = ~gnt;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (nib_cnt_q == 4'(n)) begin
                        sum_d[n*NIBBLE_W +: NIBBLE_W] = nib_s;
                    end
                end
                carry_d   = nib_c;
                nib_cnt_d = nib_cnt_q + 4'd1;
                if (nib_cnt_q == 4'(NIBBLES-1)) begin
                    cout_d  = nib_c;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 1'(FIRST_PRIO);
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            nib_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            id_q      <= id_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            nib_cnt_q <= nib_cnt_d;
        end
    end

    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_ovf_o   = ovf_q;
endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched with NIBBLES=2 and hand-computed results.
module tb_addsub_sched;
    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [1:0]      req_valid_i = '0;
    logic [1:0]      req_ready_o;
    logic [1:0][7:0] req_a_i = '0;
    logic [1:0][7:0] req_b_i = '0;
    logic [1:0]      req_sub_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic            rsp_id_o;
    logic [7:0]      rsp_sum_o;
    logic            rsp_cout_o;
    logic            rsp_ovf_o;

    int checks = 0;
    int errors = 0;

    addsub_sched #(.NIBBLES(2), .FIRST_PRIO(0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_sub_i   (req_sub_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_cout_o  (rsp_cout_o),
        .rsp_ovf_o   (rsp_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for rsp_valid at negedges; lat counts cycles after the transfer cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk_i);
        while (!rsp_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic accept_rsp();
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("rsp_valid_after_accept", 32'(rsp_valid_o), 32'd0);
    endtask

    task automatic do_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        @(posedge clk_i); #1;
        req_valid_i[id] = 1'b1;
        req_a_i[id]     = a;
        req_b_i[id]     = b;
        req_sub_i[id]   = sub;
        @(negedge clk_i);
        check({tag, "_ready"}, 32'(req_ready_o), 32'(2'b01 << id));
        @(posedge clk_i); #1;
        req_valid_i[id] = 1'b0;
        req_a_i[id]     = ~a;
        req_b_i[id]     = ~b;
        req_sub_i[id]   = ~sub;
        wait_rsp(lat);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_id"},      32'(rsp_id_o), 32'(id));
        check({tag, "_sum"},     32'(rsp_sum_o), 32'(e_sum));
        check({tag, "_cout"},    32'(rsp_cout_o), 32'(e_cout));
        check({tag, "_ovf"},     32'(rsp_ovf_o), 32'(e_ovf));
        accept_rsp();
    endtask

    task automatic arb_round(input string tag, input int exp_id, input logic [7:0] e_sum);
        int lat;
        @(negedge clk_i);
        check({tag, "_ready_onehot"}, 32'(req_ready_o), 32'(2'b01 << exp_id));
        wait_rsp(lat);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_id"},  32'(rsp_id_o), 32'(exp_id));
        check({tag, "_sum"}, 32'(rsp_sum_o), 32'(e_sum));
        check({tag, "_ready_busy"}, 32'(req_ready_o), 32'd0);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int seen;
        int lat;
        req_valid_i = 2'b11;
        #3;
        check("reset_ready", 32'(req_ready_o), 32'd0);
        check("reset_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_sum",   32'(rsp_sum_o), 32'd0);
        check("reset_flags", 32'({rsp_id_o, rsp_cout_o, rsp_ovf_o}), 32'd0);
        req_valid_i = 2'b00;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        do_op("add_3c_25",  0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);
        do_op("sub_10_01",  1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        do_op("sub_00_01",  1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        do_op("add_7f_01",  0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("sub_80_01",  0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op("add_ff_01",  1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        // Arbitration from a fresh reset with both requesters always valid.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #2;
        rst_i       = 1'b0;
        req_a_i[0]  = 8'h01; req_b_i[0] = 8'h02; req_sub_i[0] = 1'b0;
        req_a_i[1]  = 8'h05; req_b_i[1] = 8'h03; req_sub_i[1] = 1'b1;
        req_valid_i = 2'b11;
        arb_round("arb0", 0, 8'h03);
        arb_round("arb1", 1, 8'h02);
        arb_round("arb2", 0, 8'h03);
        req_valid_i = 2'b00;

        // rr_ptr now favours 1; a lone requester 0 must still win.
        do_op("lone_req0", 0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Backpressure: hold DONE while requester 1 waits.
        @(posedge clk_i); #1;
        req_valid_i[0] = 1'b1; req_a_i[0] = 8'hA5; req_b_i[0] = 8'h5A; req_sub_i[0] = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i[0] = 1'b0;
        req_valid_i[1] = 1'b1; req_a_i[1] = 8'h01; req_b_i[1] = 8'h01; req_sub_i[1] = 1'b0;
        wait_rsp(lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_valid_hold", 32'(rsp_valid_o), 32'd1);
            check("bp_sum_hold",   32'({rsp_id_o, rsp_cout_o, rsp_ovf_o, rsp_sum_o}), 32'({1'b0, 1'b0, 1'b0, 8'hFF}));
            check("bp_ready_low",  32'(req_ready_o), 32'd0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
        check("bp_idle_ready", 32'(req_ready_o), 32'b10);
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        wait_rsp(lat);
        check("bp_next_sum", 32'(rsp_sum_o), 32'h02);
        accept_rsp();

        // Reset in the middle of RUN drops the op.
        @(posedge clk_i); #1;
        req_valid_i[0] = 1'b1; req_a_i[0] = 8'h33; req_b_i[0] = 8'h44; req_sub_i[0] = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        check("rst_pre_sum", 32'(rsp_sum_o != 8'h00), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_mid_sum",   32'(rsp_sum_o), 32'd0);
        check("rst_mid_flags", 32'({rsp_id_o, rsp_cout_o, rsp_ovf_o}), 32'd0);
        check("rst_mid_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen++;
        end
        rsp_ready_i = 1'b0;
        check("rst_no_rsp", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
